// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC,
// word stride and the {pc, inst} entry layout held in the queue.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_OFFSET      = 32'd4;
  localparam int          ENTRY_W          = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                              input logic [31:0] inst);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// DEPTH x 64 register array: one synchronous write port, one combinational
// read port. Contents are intentionally not reset.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t  wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t  rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, drives the ROM word address and
// buffers {pc, inst} pairs so issue stalls do not stall fetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ROM_AW   = 7,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_inst,
  output logic [31:0]                fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_enq;
  logic          do_deq;
  logic          not_empty;
  fetch_entry_t  head;
  fetch_entry_t  new_entry;

  assign rom_addr  = fetch_pc[ROM_AW+1:2];
  assign not_empty = (count != '0);

  // Redirect overrides both directions; a full queue may still enqueue
  // when its head leaves in the same cycle.
  assign do_deq = not_empty & deq_ready & ~redirect;
  assign do_enq = ~redirect & ((count < DEPTH_C) | do_deq);

  assign new_entry = make_entry(fetch_pc, rom_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + WORD_OFFSET;
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (do_enq),
    .wr_addr (wr_ptr),
    .wr_data (new_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Head is gated on occupancy only, so deq_ready never reaches deq_*.
  assign deq_valid = not_empty;
  assign deq_pc    = not_empty ? head.pc   : 32'h0;
  assign deq_inst  = not_empty ? head.inst : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based model of the
// fetch/issue rules, with directed scenarios and a randomized run.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic [31:0] fetch_pc;
  logic [2:0]  count;

  logic [31:0] rom [128];
  assign rom_data = rom[rom_addr];

  int total = 0;
  int bad   = 0;

  logic [63:0] mq [$];
  logic [31:0] m_pc;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .ROM_AW   (7),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_pc      (deq_pc),
    .deq_inst    (deq_inst),
    .fetch_pc    (fetch_pc),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_head_pc();
    return (mq.size() != 0) ? mq[0][63:32] : 32'h0;
  endfunction

  function automatic logic [31:0] m_head_inst();
    return (mq.size() != 0) ? mq[0][31:0] : 32'h0;
  endfunction

  // One clock edge, with the model advanced by the rules on the same inputs.
  task automatic tick();
    bit deq, enq;
    logic [31:0] pc0;
    @(posedge clk);
    if (rst) begin
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        pc0 = m_pc;
        deq = (mq.size() != 0) && deq_ready;
        enq = (mq.size() < DEPTH) || deq;
        if (deq) void'(mq.pop_front());
        if (enq) begin
          mq.push_back({pc0, rom[pc0[8:2]]});
          m_pc = pc0 + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    redirect = 0; redirect_pc = 0; deq_ready = 0;
    rst = 0;
    mq.delete();
    m_pc = 32'h0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 1; redirect = 0; deq_ready = 0;
    #2 rst = 0;
    mq.delete(); m_pc = 0;
    #1;
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", deq_valid); end
    total++; if (deq_pc !== 32'h0 || deq_inst !== 32'h0) begin bad++; $display("FAIL reset_head got=%h/%h want=0/0", deq_pc, deq_inst); end
    total++; if (count !== 3'd0 || fetch_pc !== 32'h0 || rom_addr !== 7'd0) begin bad++; $display("FAIL reset_state count=%0d pc=%h addr=%0d want 0/0/0", count, fetch_pc, rom_addr); end
    tick();
    rst = 1;
    tick();
    total++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0 || deq_inst !== rom[0]) begin bad++; $display("FAIL reset_first got v=%0b pc=%h inst=%h want 1/0/%h", deq_valid, deq_pc, deq_inst, rom[0]); end
  endtask

  task automatic test_stream();
    do_reset();
    deq_ready = 1;
    tick();
    for (int k = 0; k < 10; k++) begin
      total++; if (deq_pc !== 32'(4*k) || deq_inst !== 32'(k)) begin bad++; $display("FAIL stream_head k=%0d got=%h/%h want=%h/%h", k, deq_pc, deq_inst, 4*k, k); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count k=%0d got=%0d want=1", k, count); end
      tick();
    end
  endtask

  task automatic test_full();
    int exp_cnt;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_cnt = (k < 4) ? k : 4;
      total++; if (count !== 3'(exp_cnt)) begin bad++; $display("FAIL fill_count k=%0d got=%0d want=%0d", k, count, exp_cnt); end
    end
    total++; if (fetch_pc !== 32'h10) begin bad++; $display("FAIL full_pc_hold got=%h want=00000010", fetch_pc); end
    total++; if (deq_pc !== 32'h0) begin bad++; $display("FAIL full_head got=%h want=0", deq_pc); end
    deq_ready = 1;
    tick();
    total++; if (count !== 3'd4 || fetch_pc !== 32'h14) begin bad++; $display("FAIL full_deq_enq count=%0d pc=%h want 4/14", count, fetch_pc); end
    deq_ready = 0;
    tick();
    deq_ready = 1;
    for (int k = 1; k <= 6; k++) begin
      total++; if (deq_pc !== 32'(4*k) || deq_inst !== 32'(k)) begin bad++; $display("FAIL wrap_order k=%0d got=%h/%h want=%h/%h", k, deq_pc, deq_inst, 4*k, k); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) tick();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d want=3", count); end
    deq_ready = 1; redirect = 1; redirect_pc = 32'h40;
    tick();
    redirect = 0; deq_ready = 0;
    total++; if (count !== 3'd0 || deq_valid !== 1'b0 || deq_pc !== 32'h0) begin bad++; $display("FAIL redir_flush count=%0d v=%0b pc=%h want 0/0/0", count, deq_valid, deq_pc); end
    total++; if (fetch_pc !== 32'h40 || rom_addr !== 7'd16) begin bad++; $display("FAIL redir_pc got=%h addr=%0d want=40/16", fetch_pc, rom_addr); end
    tick();
    total++; if (deq_valid !== 1'b1 || deq_pc !== 32'h40 || deq_inst !== 32'd16) begin bad++; $display("FAIL redir_head got v=%0b %h/%h want 1/40/10", deq_valid, deq_pc, deq_inst); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (2) tick();
    redirect = 1; redirect_pc = 32'h20;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect = 0; deq_ready = 1;
    total++; if (fetch_pc !== 32'h80 || count !== 3'd0) begin bad++; $display("FAIL b2b_pc got=%h count=%0d want=80/0", fetch_pc, count); end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (deq_pc !== 32'h80 + 32'(4*k) || deq_pc == 32'h20) begin bad++; $display("FAIL b2b_head k=%0d got=%h want=%h", k, deq_pc, 32'h80 + 32'(4*k)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) tick();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL areset_pre got=%0d want=2", count); end
    #2 rst = 0;
    mq.delete(); m_pc = 0;
    #1;
    total++; if (deq_valid !== 1'b0 || count !== 3'd0 || fetch_pc !== 32'h0) begin bad++; $display("FAIL areset_now v=%0b count=%0d pc=%h want 0/0/0", deq_valid, count, fetch_pc); end
    tick();
    rst = 1;
    tick();
    total++; if (deq_pc !== 32'h0 || count !== 3'd1 || fetch_pc !== 32'h4) begin bad++; $display("FAIL areset_restart pc=%h count=%0d fpc=%h want 0/1/4", deq_pc, count, fetch_pc); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      deq_ready = ($urandom_range(0, 3) != 0);
      redirect  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = 32'hFFFF_FFF4;
        default: redirect_pc = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
      endcase
      if (c % 50 == 25) deq_ready = 0;
      tick();
      total++;
      if (deq_valid !== (mq.size() != 0) || deq_pc !== m_head_pc() ||
          deq_inst !== m_head_inst() || count !== 3'(mq.size()) ||
          fetch_pc !== m_pc || rom_addr !== m_pc[8:2]) begin
        bad++;
        if (errs < 10)
          $display("FAIL random c=%0d got v=%0b pc=%h inst=%h cnt=%0d fpc=%h want v=%0b pc=%h inst=%h cnt=%0d fpc=%h",
                   c, deq_valid, deq_pc, deq_inst, count, fetch_pc,
                   mq.size() != 0, m_head_pc(), m_head_inst(), mq.size(), m_pc);
        errs++;
      end
    end
    redirect = 0; deq_ready = 0;
  endtask

  initial begin
    rst = 1; redirect = 0; redirect_pc = 0; deq_ready = 0;
    for (int i = 0; i < 128; i++) rom[i] = 32'(i);
    #1;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
